// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: measures an incoming PWM waveform and reports its period
// in clk cycles and its duty cycle as an 8-bit code floor(256*high/period),
// saturated to 255. A missing rising edge for TIMEOUT cycles flags the input
// as stuck and reports the static level as duty 0 or 255.
module pwm_duty_capture #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [7:0]       duty_o,
  output logic             duty_valid,
  output logic [CNT_W-1:0] period_o,
  output logic             stuck,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LAST_STEP = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DIVIDE,
    STUCK
  } state_t;

  state_t           state;

  logic             s1;
  logic             s2;
  logic             s2_q;
  logic             rise_det;

  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             timeout_hit;

  // Divider working registers
  logic [CNT_W-1:0] snap_p;
  logic [CNT_W-1:0] rem;
  logic             h_lsb;
  logic [8:0]       quo;
  logic [3:0]       step;

  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   diff;
  logic             fits;
  logic [CNT_W-1:0] rem_next;

  assign rise_det    = s2 & ~s2_q;
  assign timeout_hit = (period_cnt == TMO);

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      s2_q <= s2;
    end
  end

  // Free-running period and high-time counters, restarted on every rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise_det) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else begin
      if (period_cnt != CNT_MAX) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end
      if (s2 && (high_cnt != CNT_MAX)) begin
        high_cnt <= high_cnt + CNT_W'(1);
      end
    end
  end

  // One restoring-division step. The remainder is preloaded with H>>1 and the
  // first step shifts in H[0], so step 0 tests H>=P (quotient bit 8) and the
  // next eight steps shift in the zero low byte of {H,8'b0}.
  always_comb begin
    trial    = {rem, ((step == 4'd0) ? h_lsb : 1'b0)};
    diff     = trial - {1'b0, snap_p};
    fits     = (trial >= {1'b0, snap_p});
    rem_next = fits ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
  end

  // A rising edge seen while the divider is busy is dropped and flagged at once
  always_comb begin
    overrun = (state == DIVIDE) && rise_det && !timeout_hit;
  end

  // Measurement FSM: arms on the first edge, snapshots on each later edge,
  // runs the divider and publishes results; timeout overrides all non-stuck states
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      duty_o     <= '0;
      duty_valid <= 1'b0;
      period_o   <= '0;
      stuck      <= 1'b0;
      snap_p     <= '0;
      rem        <= '0;
      h_lsb      <= 1'b0;
      quo        <= '0;
      step       <= '0;
    end else begin
      duty_valid <= 1'b0;
      if (timeout_hit && (state != STUCK)) begin
        duty_o     <= s2 ? 8'hFF : 8'h00;
        period_o   <= '0;
        duty_valid <= 1'b1;
        stuck      <= 1'b1;
        state      <= STUCK;
      end else begin
        case (state)
          IDLE: begin
            if (rise_det) begin
              state <= ARMED;
            end
          end
          ARMED: begin
            if (rise_det) begin
              snap_p <= period_cnt;
              rem    <= high_cnt >> 1;
              h_lsb  <= high_cnt[0];
              quo    <= '0;
              step   <= '0;
              state  <= DIVIDE;
            end
          end
          DIVIDE: begin
            if (step == LAST_STEP) begin
              duty_o     <= quo[8] ? 8'hFF : quo[7:0];
              period_o   <= snap_p;
              duty_valid <= 1'b1;
              state      <= ARMED;
            end else begin
              rem  <= rem_next;
              quo  <= {quo[7:0], fits};
              step <= step + 4'd1;
            end
          end
          STUCK: begin
            if (rise_det) begin
              stuck <= 1'b0;
              state <= ARMED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Testbench for pwm_duty_capture: directed and random PWM waveforms checked
// cycle by cycle against a reference model built from the sampled input history.
module tb_pwm_duty_capture;

  localparam int CNT_W = 32;
  localparam int TMO   = 4000;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [7:0]       duty_o;
  logic             duty_valid;
  logic [CNT_W-1:0] period_o;
  logic             stuck;
  logic             overrun;

  always #5 clk = ~clk;

  pwm_duty_capture #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .duty_o    (duty_o),
    .duty_valid(duty_valid),
    .period_o  (period_o),
    .stuck     (stuck),
    .overrun   (overrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: hist[k] is the input value sampled at edge k
  bit hist [0:65535];
  int k = 3;
  int last_rise = 0;
  int tmo_edge = 0;
  bit have_ref = 0;
  bit stuck_m = 0;
  bit pending = 0;
  int pend_edge = 0;
  int pend_duty = 0;
  int pend_period = 0;
  int e_duty = 0;
  int e_period = 0;
  bit e_valid = 0;
  bit e_ovr = 0;

  int n_valid_seen = 0;
  int n_ovr_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Expected behaviour at edge k, derived from sampled history: a rise is seen
  // two edges after it is sampled; a measured period runs from one sampled rise
  // to the next; results appear ten edges after an accepted rise.
  task automatic model_edge(input bit r);
    bit rise, tmo, busy;
    int prev, hh, p;
    e_valid = 0;
    if (r) begin
      hist[k] = 0; hist[k-1] = 0; hist[k-2] = 0;
      have_ref = 0; stuck_m = 0; pending = 0;
      e_duty = 0; e_period = 0;
      tmo_edge = k + 1 + TMO;
      last_rise = k;
    end else begin
      rise = hist[k-2] && !hist[k-3];
      tmo  = !stuck_m && (k == tmo_edge);
      busy = pending && (k <= pend_edge);
      if (tmo) begin
        e_valid = 1; e_duty = hist[k-2] ? 255 : 0; e_period = 0;
        stuck_m = 1; have_ref = 0; pending = 0;
      end else if (pending && k == pend_edge) begin
        e_valid = 1; e_duty = pend_duty; e_period = pend_period;
        pending = 0;
      end
      if (rise) begin
        prev = last_rise;
        last_rise = k;
        tmo_edge = k + TMO;
        if (!tmo && !busy) begin
          if (stuck_m) begin
            stuck_m = 0; have_ref = 1;
          end else if (have_ref) begin
            p = k - prev;
            hh = 0;
            for (int i = prev - 2; i <= k - 3; i++) hh += int'(hist[i]);
            pend_duty = (256 * hh) / p;
            if (pend_duty > 255) pend_duty = 255;
            pend_period = p;
            pending = 1;
            pend_edge = k + 10;
          end else begin
            have_ref = 1;
          end
        end
      end
    end
    // overrun is combinational: predict it for the edge about to come
    e_ovr = (hist[k-1] && !hist[k-2]) && pending && ((k + 1) <= pend_edge)
            && !(!stuck_m && ((k + 1) == tmo_edge));
  endtask

  task automatic tick(input bit v, input bit r);
    pwm_in = v;
    rst = r;
    @(posedge clk);
    k++;
    hist[k] = v;
    model_edge(r);
    #1;
    if (duty_valid === 1'b1) n_valid_seen++;
    if (overrun === 1'b1) n_ovr_seen++;
    chk("duty_valid", duty_valid, e_valid);
    chk("stuck", stuck, stuck_m);
    chk("overrun", overrun, e_ovr);
    chk("duty_o", duty_o, e_duty);
    chk("period_o", period_o, e_period);
  endtask

  task automatic run_pwm(input int period, input int high, input int n);
    for (int j = 0; j < n; j++)
      for (int c = 0; c < period; c++) tick(c < high, 1'b0);
  endtask

  task automatic hold(input bit v, input int n);
    for (int j = 0; j < n; j++) tick(v, 1'b0);
  endtask

  initial begin
    int p, h;
    pwm_in = 1'b0;
    rst = 1'b1;

    // Reset state
    for (int j = 0; j < 3; j++) tick(1'b0, 1'b1);
    chk("rst_duty", duty_o, 0);
    chk("rst_period", period_o, 0);
    chk("rst_stuck", stuck, 0);
    hold(1'b0, 5);

    // Basic measurement: 100/25 over four periods gives three results
    n_valid_seen = 0;
    run_pwm(100, 25, 4);
    chk("t1_duty", duty_o, 64);
    chk("t1_period", period_o, 100);
    chk("t1_nvalid", n_valid_seen, 3);

    // Duty code corner values
    run_pwm(256, 128, 3);
    chk("t2a_duty", duty_o, 128);
    chk("t2a_period", period_o, 256);
    run_pwm(100, 99, 3);
    chk("t2b_duty", duty_o, 253);
    run_pwm(3000, 1, 3);
    chk("t2c_duty", duty_o, 0);
    chk("t2c_period", period_o, 3000);

    // Stuck high, recovery, stuck low, recovery
    run_pwm(100, 25, 3);
    hold(1'b1, TMO + 20);
    chk("t3a_stuck", stuck, 1);
    chk("t3a_duty", duty_o, 255);
    chk("t3a_period", period_o, 0);
    run_pwm(100, 25, 3);
    chk("t3b_stuck", stuck, 0);
    hold(1'b0, TMO + 20);
    chk("t3c_stuck", stuck, 1);
    chk("t3c_duty", duty_o, 0);
    run_pwm(50, 10, 3);
    chk("t3d_stuck", stuck, 0);
    chk("t3d_duty", duty_o, 51);
    chk("t3d_period", period_o, 50);

    // Short period: alternate edges arrive while dividing
    n_ovr_seen = 0;
    run_pwm(6, 3, 10);
    chk("t4_ovr_seen", (n_ovr_seen > 0), 1);
    chk("t4_period", period_o, 6);
    chk("t4_duty", duty_o, 128);

    // Reset in the middle of a division
    run_pwm(100, 50, 2);
    hold(1'b1, 4);
    tick(1'b1, 1'b1);
    chk("t5_duty", duty_o, 0);
    chk("t5_period", period_o, 0);
    chk("t5_valid", duty_valid, 0);
    run_pwm(100, 50, 3);
    chk("t5b_duty", duty_o, 128);
    chk("t5b_period", period_o, 100);

    // Loopback-style waveform: duty 0x80 over a 256-cycle period
    run_pwm(256, 128, 3);
    chk("t6_duty_near", (int'(duty_o) >= 127 && int'(duty_o) <= 129), 1);

    // Random waveforms, including short periods that overrun
    for (int it = 0; it < 8; it++) begin
      p = (it % 3 == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(13, 300));
      h = int'($urandom_range(1, p - 1));
      run_pwm(p, h, 4);
    end
    hold(1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
